// File: rtl/dec_ram_reader.sv
// Read-side controller for the ping-pong hard-decision memory: reads one
// codeword bit by bit from the selected bank and streams it as packed words.
module dec_ram_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int CODE_LEN   = 256,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bank_sel,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic [1:0]            rd_cs,
  output logic [1:0]            rd_we,
  input  logic                  rd_data0,
  input  logic                  rd_data1,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            dbg_state
);

  localparam int CW  = $clog2(OUT_WIDTH + 1);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LAST_ADDR = AW1'(CODE_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  // Handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_data/out_last are frozen while out_valid is
  // high and out_ready is low.

  state_t               state;
  logic                 bank_r;
  logic [AW1-1:0]       addr_cnt;
  logic                 inflight;
  logic                 inflight_last;
  logic [OUT_WIDTH-1:0] acc;
  logic [CW-1:0]        acc_cnt;
  logic                 final_held;

  logic                 rd_bit;
  logic                 last_ret;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [CW-1:0]        cnt_next;
  logic                 out_free;
  logic                 xfer;
  logic                 issue;

  assign rd_bit   = bank_r ? rd_data1 : rd_data0;
  assign last_ret = inflight & inflight_last;
  assign cnt_next = acc_cnt + CW'(inflight);
  assign out_free = !out_valid || out_ready;
  assign xfer     = ((cnt_next == CW'(OUT_WIDTH)) || last_ret || final_held) && out_free;

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (inflight && (acc_cnt == CW'(i))) acc_next[i] = rd_bit;
    end
  end

  // Space check also counts the word leaving this cycle, so reads keep
  // streaming at one bit per cycle across word boundaries.
  assign issue = (state == READ) &&
                 (((int'(acc_cnt) + int'(inflight)) < OUT_WIDTH) || xfer);

  assign rd_cs      = issue ? (bank_r ? 2'b10 : 2'b01) : 2'b00;
  assign rd_address = (state == READ) ? addr_cnt[ADDR_WIDTH-1:0] : '0;
  assign rd_we      = 2'b00;
  assign done       = (state == DRAIN) && out_valid && out_ready && out_last;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bank_r        <= 1'b0;
      addr_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      acc           <= '0;
      acc_cnt       <= '0;
      final_held    <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (addr_cnt == LAST_ADDR);

      case (state)
        IDLE: begin
          if (start) begin
            bank_r   <= bank_sel;
            addr_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_cnt <= addr_cnt + AW1'(1);
            if (addr_cnt == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        out_data   <= acc_next;
        out_valid  <= 1'b1;
        out_last   <= last_ret || final_held;
        acc        <= '0;
        acc_cnt    <= '0;
        final_held <= 1'b0;
      end else begin
        acc     <= acc_next;
        acc_cnt <= cnt_next;
        if (last_ret) final_held <= 1'b1;
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_ram_reader.sv
// Bench for dec_ram_reader: three instances (CODE_LEN 256, 13, 1) share a
// bit-addressable two-bank memory model and a word scoreboard.
module tb_dec_ram_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic       bank_sel;
  logic       out_ready;

  logic       busy [3];
  logic       done [3];
  logic [7:0] rd_address [3];
  logic [1:0] rd_cs [3];
  logic [1:0] rd_we [3];
  logic       rd_data0 [3];
  logic       rd_data1 [3];
  logic [7:0] out_data [3];
  logic       out_valid [3];
  logic       out_last [3];
  logic [1:0] dbg_state [3];

  always #5 clk = ~clk;

  dec_ram_reader #(.ADDR_WIDTH(8), .CODE_LEN(256), .OUT_WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .bank_sel(bank_sel),
    .busy(busy[0]), .done(done[0]), .rd_address(rd_address[0]), .rd_cs(rd_cs[0]),
    .rd_we(rd_we[0]), .rd_data0(rd_data0[0]), .rd_data1(rd_data1[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_last(out_last[0]), .dbg_state(dbg_state[0]));

  dec_ram_reader #(.ADDR_WIDTH(8), .CODE_LEN(13), .OUT_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .bank_sel(bank_sel),
    .busy(busy[1]), .done(done[1]), .rd_address(rd_address[1]), .rd_cs(rd_cs[1]),
    .rd_we(rd_we[1]), .rd_data0(rd_data0[1]), .rd_data1(rd_data1[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_last(out_last[1]), .dbg_state(dbg_state[1]));

  dec_ram_reader #(.ADDR_WIDTH(8), .CODE_LEN(1), .OUT_WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .bank_sel(bank_sel),
    .busy(busy[2]), .done(done[2]), .rd_address(rd_address[2]), .rd_cs(rd_cs[2]),
    .rd_we(rd_we[2]), .rd_data0(rd_data0[2]), .rd_data1(rd_data1[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_last(out_last[2]), .dbg_state(dbg_state[2]));

  // Two synchronous 1-bit banks, data one cycle after chip select.
  logic mem0 [256];
  logic mem1 [256];

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd_cs[g][0]) rd_data0[g] <= mem0[rd_address[g]];
      if (rd_cs[g][1]) rd_data1[g] <= mem1[rd_address[g]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard entries are {last, data}.
  logic [8:0] exp_q [$];
  logic [8:0] e;

  int         lens [3]        = '{256, 13, 1};
  int         cyc             = 0;
  int         reads [3]       = '{0, 0, 0};
  int         first_cs [3]    = '{0, 0, 0};
  int         last_cs [3]     = '{0, 0, 0};
  int         start_cyc [3]   = '{0, 0, 0};
  int         first_valid [3] = '{-1, -1, -1};
  int         done_cnt [3]    = '{0, 0, 0};
  logic       prev_hold [3]   = '{1'b0, 1'b0, 1'b0};
  logic [7:0] prev_data [3];
  logic       prev_last [3];
  int         viol = 0, wrong_bank = 0, addr_err = 0, stall_err = 0, got_cnt = 0;
  int         cur_bank = 0;
  logic [7:0] first_got, last_got;
  logic       mon_en = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (rd_cs[i] == 2'b11) viol++;
        if (rd_we[i] != 2'b00) viol++;
        if (rd_cs[i] != 2'b00 && !busy[i]) viol++;
        if (start[i] && !busy[i]) start_cyc[i] = cyc;
        if (rd_cs[i] != 2'b00) begin
          if (rd_cs[i][1-cur_bank]) wrong_bank++;
          if (rd_address[i] !== 8'(reads[i])) addr_err++;
          if (reads[i] == 0) first_cs[i] = cyc;
          last_cs[i] = cyc;
          reads[i]++;
        end
        if (out_valid[i] && first_valid[i] < 0) first_valid[i] = cyc;
        if (prev_hold[i] && (out_valid[i] !== 1'b1 || out_data[i] !== prev_data[i] ||
                             out_last[i] !== prev_last[i])) stall_err++;
        prev_hold[i] = out_valid[i] && !out_ready;
        prev_data[i] = out_data[i];
        prev_last[i] = out_last[i];
        if (done[i]) begin
          done_cnt[i]++;
          if (!(out_valid[i] && out_ready && out_last[i]) || !busy[i]) viol++;
        end
        if (out_valid[i] && out_ready && out_last[i] && !done[i]) viol++;
        if (out_valid[i] && out_ready && mon_en) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_word: got %0h expected no word", out_data[i]);
          end else begin
            e = exp_q.pop_front();
            check("word", {out_last[i], out_data[i]}, e);
            if (got_cnt == 0) first_got = out_data[i];
            last_got = out_data[i];
            got_cnt++;
          end
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) prev_hold[i] = 1'b0;
    end
  end

  typedef struct {
    int         inst;
    logic       bank;
    int         fill;
    int         pct;
    logic       restart;
    int         exp_words;
    logic [7:0] exp_first;
    logic [7:0] exp_lastw;
  } case_t;

  case_t cases [7];

  function automatic logic [7:0] pat(input int k);
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'h3C;
    return 8'(k * 37 + 11);
  endfunction

  task automatic fill_mem(input int fill);
    logic [7:0] b;
    for (int k = 0; k < 256; k++) begin
      b = pat(k / 8);
      case (fill)
        0:       begin mem0[k] = b[k % 8]; mem1[k] = ~b[k % 8]; end
        1:       begin mem0[k] = 1'b1;     mem1[k] = 1'b0;      end
        default: begin mem0[k] = 1'b0;     mem1[k] = 1'b1;      end
      endcase
    end
  endtask

  task automatic clear_counters(input int i);
    reads[i] = 0; done_cnt[i] = 0; first_valid[i] = -1;
    viol = 0; wrong_bank = 0; addr_err = 0; stall_err = 0; got_cnt = 0;
    first_got = 8'h0; last_got = 8'h0;
  endtask

  task automatic run_case(input int c);
    case_t      r;
    int         i, len, nwords, t;
    logic [7:0] w;
    r      = cases[c];
    i      = r.inst;
    len    = lens[i];
    nwords = (len + 7) / 8;
    fill_mem(r.fill);
    for (int k = 0; k < nwords; k++) begin
      w = 8'h00;
      for (int b = 0; b < 8; b++)
        if (k * 8 + b < len) w[b] = r.bank ? mem1[k * 8 + b] : mem0[k * 8 + b];
      exp_q.push_back({(k == nwords - 1), w});
    end
    clear_counters(i);
    cur_bank  = int'(r.bank);
    bank_sel  = r.bank;
    start[i]  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    bank_sel = ~r.bank;
    t = 0;
    while (done_cnt[i] == 0 && t < 4000) begin
      out_ready = ($urandom_range(0, 99) < r.pct);
      start[i]  = r.restart && (t == 30 || t == 280);
      @(posedge clk); #1;
      t++;
    end
    start[i]  = 1'b0;
    out_ready = 1'b1;
    check("done_seen", (done_cnt[i] != 0), 1);
    repeat (6) @(posedge clk);
    #1;
    check("busy_after", busy[i], 0);
    check("done_pulses", done_cnt[i], 1);
    check("reads", reads[i], len);
    check("wrong_bank", wrong_bank, 0);
    check("addr_seq", addr_err, 0);
    check("protocol", viol, 0);
    check("stall_stable", stall_err, 0);
    check("word_count", got_cnt, r.exp_words);
    check("first_word", first_got, r.exp_first);
    check("last_word", last_got, r.exp_lastw);
    check("queue_empty", exp_q.size(), 0);
    check("start_latency", first_cs[i] - start_cyc[i], 1);
    if (r.pct == 100) begin
      check("consecutive_reads", last_cs[i] - first_cs[i] + 1, len);
      check("first_valid_latency", first_valid[i] - first_cs[i], ((len < 8) ? len : 8) + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    cases[0] = '{0, 1'b0, 0, 100, 1'b0, 32, 8'hA5, 8'h86};
    cases[1] = '{0, 1'b1, 1, 100, 1'b1, 32, 8'h00, 8'h00};
    cases[2] = '{0, 1'b0, 0,  50, 1'b0, 32, 8'hA5, 8'h86};
    cases[3] = '{1, 1'b0, 1, 100, 1'b0,  2, 8'hFF, 8'h1F};
    cases[4] = '{2, 1'b1, 2, 100, 1'b0,  1, 8'h01, 8'h01};
    cases[5] = '{2, 1'b1, 1, 100, 1'b0,  1, 8'h00, 8'h00};
    cases[6] = '{1, 1'b1, 2,  50, 1'b1,  2, 8'hFF, 8'h1F};

    reset = 1'b1; start = 3'b000; bank_sel = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", busy[i], 0);
      check("rst_outs", {done[i], out_valid[i], out_last[i], out_data[i]}, 0);
      check("rst_rd", {rd_cs[i], rd_we[i], rd_address[i]}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int c = 0; c < 7; c++) run_case(c);

    // Reset in the middle of READ, then a fresh codeword from address 0.
    mon_en = 1'b0;
    fill_mem(0);
    clear_counters(0);
    cur_bank = 0; bank_sel = 1'b0; start[0] = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", busy[0], 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cs", rd_cs[0], 0);
    check("mid_rst_valid", out_valid[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_data", out_data[0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_case(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
